// File: rtl/board_shot_grid.sv
// Battleship-style shot grid: ships are placed in SETUP, shots are resolved in PLAY,
// and OVER is entered once every placed ship cell has been hit.
module board_shot_grid #(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS),
  localparam int N    = ROWS * COLS,
  localparam int NW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  input  logic          start,
  input  logic          new_game,
  input  logic          shot_valid,
  input  logic [RW-1:0] shot_row,
  input  logic [CW-1:0] shot_col,
  output logic          shot_ready,
  output logic          result_valid,
  output logic          result_hit,
  output logic          result_repeat,
  output logic          result_invalid,
  output logic [N-1:0]  ship_map,
  output logic [N-1:0]  shot_map,
  output logic [NW-1:0] ships_count,
  output logic [NW-1:0] hits_count,
  output logic          game_over
);

  localparam int IW = $clog2(N);
  localparam logic [NW-1:0] CNT_ONE  = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] CNT_ZERO = {NW{1'b0}};

  typedef enum logic [1:0] {
    SETUP = 2'b00,
    PLAY  = 2'b01,
    OVER  = 2'b10
  } state_t;

  state_t          state_r, next_state_s;
  logic [N-1:0]    ship_map_s, shot_map_s;
  logic [NW-1:0]   ships_s, hits_s;
  logic            res_valid_s, res_hit_s, res_repeat_s, res_invalid_s;
  logic            load_in_range_s, shot_in_range_s;
  logic [IW-1:0]   load_idx_s, shot_idx_s;

  // Index values are only consumed when the coordinates are in range, so truncation is harmless.
  assign load_in_range_s = (int'(load_row) < ROWS) && (int'(load_col) < COLS);
  assign shot_in_range_s = (int'(shot_row) < ROWS) && (int'(shot_col) < COLS);
  assign load_idx_s      = IW'(int'(load_row) * COLS + int'(load_col));
  assign shot_idx_s      = IW'(int'(shot_row) * COLS + int'(shot_col));

  // Next-state, next-board and shot-result computation.
  always_comb begin
    next_state_s  = state_r;
    ship_map_s    = ship_map;
    shot_map_s    = shot_map;
    ships_s       = ships_count;
    hits_s        = hits_count;
    res_valid_s   = 1'b0;
    res_hit_s     = 1'b0;
    res_repeat_s  = 1'b0;
    res_invalid_s = 1'b0;
    case (state_r)
      SETUP: begin
        if (load_valid && load_in_range_s && !ship_map[load_idx_s]) begin
          ship_map_s[load_idx_s] = 1'b1;
          ships_s                = ships_count + CNT_ONE;
        end else begin
          ships_s = ships_count;
        end
        // Start sees the count including a same-cycle placement.
        if (start && (ships_s != CNT_ZERO)) begin
          next_state_s = PLAY;
        end else begin
          next_state_s = SETUP;
        end
      end
      PLAY: begin
        if (shot_valid) begin
          res_valid_s = 1'b1;
          if (!shot_in_range_s) begin
            res_invalid_s = 1'b1;
          end else if (shot_map[shot_idx_s]) begin
            res_repeat_s = 1'b1;
            res_hit_s    = ship_map[shot_idx_s];
          end else begin
            shot_map_s[shot_idx_s] = 1'b1;
            if (ship_map[shot_idx_s]) begin
              res_hit_s = 1'b1;
              hits_s    = hits_count + CNT_ONE;
              if (hits_s == ships_count) begin
                next_state_s = OVER;
              end else begin
                next_state_s = PLAY;
              end
            end else begin
              res_hit_s = 1'b0;
            end
          end
        end else begin
          res_valid_s = 1'b0;
        end
      end
      OVER: begin
        if (new_game) begin
          next_state_s = SETUP;
          ship_map_s   = {N{1'b0}};
          shot_map_s   = {N{1'b0}};
          ships_s      = CNT_ZERO;
          hits_s       = CNT_ZERO;
        end else begin
          next_state_s = OVER;
        end
      end
      default: begin
        next_state_s = SETUP;
      end
    endcase
  end

  // State, board and result registers; reset also drops any pending result pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= SETUP;
      ship_map       <= {N{1'b0}};
      shot_map       <= {N{1'b0}};
      ships_count    <= CNT_ZERO;
      hits_count     <= CNT_ZERO;
      result_valid   <= 1'b0;
      result_hit     <= 1'b0;
      result_repeat  <= 1'b0;
      result_invalid <= 1'b0;
      shot_ready     <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      ship_map       <= ship_map_s;
      shot_map       <= shot_map_s;
      ships_count    <= ships_s;
      hits_count     <= hits_s;
      result_valid   <= res_valid_s;
      result_hit     <= res_hit_s;
      result_repeat  <= res_repeat_s;
      result_invalid <= res_invalid_s;
      shot_ready     <= (next_state_s == PLAY);
      game_over      <= (next_state_s == OVER);
    end
  end

endmodule

// File: tb/tb_board_shot_grid.sv
// Directed bench for board_shot_grid: a default 8x8 instance and a 5x6 instance
// for out-of-range coordinate handling.
module tb_board_shot_grid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // 8x8 instance
  logic       a_load_valid = 1'b0, a_start = 1'b0, a_new_game = 1'b0, a_shot_valid = 1'b0;
  logic [2:0] a_load_row = 3'd0, a_load_col = 3'd0, a_shot_row = 3'd0, a_shot_col = 3'd0;
  logic       a_shot_ready, a_rv, a_hit, a_rep, a_inv, a_over;
  logic [63:0] a_ship_map, a_shot_map;
  logic [6:0]  a_ships, a_hits;

  board_shot_grid dut_a (
    .clk(clk), .reset(reset),
    .load_valid(a_load_valid), .load_row(a_load_row), .load_col(a_load_col),
    .start(a_start), .new_game(a_new_game),
    .shot_valid(a_shot_valid), .shot_row(a_shot_row), .shot_col(a_shot_col),
    .shot_ready(a_shot_ready), .result_valid(a_rv), .result_hit(a_hit),
    .result_repeat(a_rep), .result_invalid(a_inv),
    .ship_map(a_ship_map), .shot_map(a_shot_map),
    .ships_count(a_ships), .hits_count(a_hits), .game_over(a_over)
  );

  // 5x6 instance
  logic       b_load_valid = 1'b0, b_start = 1'b0, b_new_game = 1'b0, b_shot_valid = 1'b0;
  logic [2:0] b_load_row = 3'd0, b_load_col = 3'd0, b_shot_row = 3'd0, b_shot_col = 3'd0;
  logic       b_shot_ready, b_rv, b_hit, b_rep, b_inv, b_over;
  logic [29:0] b_ship_map, b_shot_map;
  logic [4:0]  b_ships, b_hits;

  board_shot_grid #(.ROWS(5), .COLS(6)) dut_b (
    .clk(clk), .reset(reset),
    .load_valid(b_load_valid), .load_row(b_load_row), .load_col(b_load_col),
    .start(b_start), .new_game(b_new_game),
    .shot_valid(b_shot_valid), .shot_row(b_shot_row), .shot_col(b_shot_col),
    .shot_ready(b_shot_ready), .result_valid(b_rv), .result_hit(b_hit),
    .result_repeat(b_rep), .result_invalid(b_inv),
    .ship_map(b_ship_map), .shot_map(b_shot_map),
    .ships_count(b_ships), .hits_count(b_hits), .game_over(b_over)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [2:0] r, input logic [2:0] c, input logic st);
    a_load_valid = 1'b1; a_load_row = r; a_load_col = c; a_start = st;
    tick();
    a_load_valid = 1'b0; a_start = 1'b0;
  endtask

  task automatic a_result(input string tag, input logic rv, input logic h, input logic rp, input logic iv);
    check_eq({tag, "_rv"}, 64'(a_rv), 64'(rv));
    check_eq({tag, "_flags"}, 64'({a_hit, a_rep, a_inv}), 64'({h, rp, iv}));
  endtask

  initial begin
    // reset state
    tick();
    check_eq("rst_ship_map", a_ship_map, 64'h0);
    check_eq("rst_counts", 64'({a_ships, a_hits}), 64'h0);
    check_eq("rst_ctrl", 64'({a_shot_ready, a_over, a_rv}), 64'h0);
    reset = 1'b0;

    // start with no ships is ignored
    a_start = 1'b1; tick(); a_start = 1'b0;
    check_eq("empty_start_ready", 64'(a_shot_ready), 64'h0);

    // placement with a duplicate
    a_load(3'd0, 3'd0, 1'b0);
    a_load(3'd0, 3'd1, 1'b0);
    a_load(3'd0, 3'd1, 1'b0);
    check_eq("dup_ships_count", 64'(a_ships), 64'd2);
    check_eq("dup_ship_map", a_ship_map, 64'h3);
    check_eq("setup_ready", 64'(a_shot_ready), 64'h0);

    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("rerst_ship_map", a_ship_map, 64'h0);

    // (3,4) alone, then (3,5) together with start
    a_load(3'd3, 3'd4, 1'b0);
    a_load(3'd3, 3'd5, 1'b1);
    check_eq("start_ready", 64'(a_shot_ready), 64'h1);
    check_eq("start_ships", 64'(a_ships), 64'd2);
    check_eq("start_map", a_ship_map, 64'h0000_0000_3000_0000);
    a_load(3'd7, 3'd7, 1'b0);
    check_eq("play_load_ignored", 64'(a_ships), 64'd2);

    // hit, miss, repeat in consecutive cycles
    a_shot_valid = 1'b1; a_shot_row = 3'd3; a_shot_col = 3'd4;
    tick();
    a_result("hit1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("hit1_count", 64'(a_hits), 64'd1);
    check_eq("hit1_shot_map", a_shot_map, 64'h0000_0000_1000_0000);
    a_shot_row = 3'd0; a_shot_col = 3'd0;
    tick();
    a_result("miss", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("miss_shot_map", a_shot_map, 64'h0000_0000_1000_0001);
    a_shot_row = 3'd3; a_shot_col = 3'd4;
    tick();
    a_result("repeat", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("repeat_count", 64'(a_hits), 64'd1);
    a_shot_valid = 1'b0;
    tick();
    a_result("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // final hit ends the game
    a_shot_valid = 1'b1; a_shot_row = 3'd3; a_shot_col = 3'd5;
    tick();
    a_result("final", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("final_over", 64'({a_over, a_shot_ready}), 64'b10);
    check_eq("final_hits", 64'(a_hits), 64'd2);
    a_shot_row = 3'd1; a_shot_col = 3'd1;
    tick();
    a_result("over_shot", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("over_shot_map", a_shot_map, 64'h0000_0000_3000_0001);
    a_shot_valid = 1'b0;
    a_new_game = 1'b1; tick(); a_new_game = 1'b0;
    check_eq("newgame_ctrl", 64'({a_over, a_shot_ready}), 64'h0);
    check_eq("newgame_maps", 64'(a_ship_map | a_shot_map), 64'h0);
    check_eq("newgame_counts", 64'({a_ships, a_hits}), 64'h0);

    // 5x6 instance: out-of-range placement and shots
    b_load_valid = 1'b1; b_load_row = 3'd5; b_load_col = 3'd0;
    tick();
    check_eq("b_oor_load", 64'(b_ships), 64'd0);
    b_load_row = 3'd0; b_load_col = 3'd0; b_start = 1'b1;
    tick();
    b_load_valid = 1'b0; b_start = 1'b0;
    check_eq("b_single_start", 64'({b_shot_ready, b_ships}), 64'({1'b1, 5'd1}));
    b_shot_valid = 1'b1; b_shot_row = 3'd5; b_shot_col = 3'd0;
    tick();
    check_eq("b_inv_row", 64'({b_rv, b_hit, b_rep, b_inv}), 64'b1001);
    b_shot_row = 3'd0; b_shot_col = 3'd6;
    tick();
    check_eq("b_inv_col", 64'({b_rv, b_hit, b_rep, b_inv}), 64'b1001);
    check_eq("b_inv_nochange", 64'({b_shot_map, b_hits}), 64'h0);
    b_shot_row = 3'd4; b_shot_col = 3'd5;
    tick();
    b_shot_valid = 1'b0;
    check_eq("b_corner_miss", 64'({b_rv, b_hit, b_rep, b_inv}), 64'b1000);
    check_eq("b_corner_map", 64'(b_shot_map), 64'h2000_0000);

    // async reset right after an accepted hit kills the pulse
    a_load(3'd2, 3'd2, 1'b0);
    a_load(3'd2, 3'd3, 1'b1);
    a_shot_valid = 1'b1; a_shot_row = 3'd2; a_shot_col = 3'd2;
    @(posedge clk);
    a_shot_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_rv", 64'({a_rv, a_hit, a_rep, a_inv}), 64'h0);
    check_eq("arst_maps", 64'(a_ship_map | a_shot_map), 64'h0);
    check_eq("arst_counts", 64'({a_ships, a_hits, a_shot_ready, a_over}), 64'h0);
    tick();
    check_eq("arst_hold_rv", 64'(a_rv), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
